// File: rtl/scroll_ctrl_pkg.sv
// Shared types and constants for the scrolling hex-display controller.
package scroll_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [4:0] CH_BLANK  = 5'd16;
  localparam logic [4:0] CH_DASH   = 5'd17;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

endpackage

// File: rtl/scroll_ctrl_char_to_seg.sv
// Character code to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module char_to_seg
  import scroll_ctrl_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      5'd0:    seg = 7'h40;
      5'd1:    seg = 7'h79;
      5'd2:    seg = 7'h24;
      5'd3:    seg = 7'h30;
      5'd4:    seg = 7'h19;
      5'd5:    seg = 7'h12;
      5'd6:    seg = 7'h02;
      5'd7:    seg = 7'h78;
      5'd8:    seg = 7'h00;
      5'd9:    seg = 7'h10;
      5'd10:   seg = 7'h08;
      5'd11:   seg = 7'h03;
      5'd12:   seg = 7'h46;
      5'd13:   seg = 7'h21;
      5'd14:   seg = 7'h06;
      5'd15:   seg = 7'h0E;
      CH_DASH: seg = SEG_DASH;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/scroll_ctrl.sv
// Scrolls a MSG_LEN-character message across six hex digits, one step every
// TICK_DIV clocks, with a write port for the message store.
module scroll_ctrl
  import scroll_ctrl_pkg::*;
#(
  parameter int MSG_LEN  = 16,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       dir,
  input  logic                       clear,
  input  logic                       load,
  input  logic [$clog2(MSG_LEN)-1:0] load_addr,
  input  logic [4:0]                 load_char,
  output logic                       load_done,
  output logic [6:0]                 next_hex0,
  output logic [6:0]                 next_hex1,
  output logic [6:0]                 next_hex2,
  output logic [6:0]                 next_hex3,
  output logic [6:0]                 next_hex4,
  output logic [6:0]                 next_hex5,
  output logic                       hex_en,
  output logic                       ledr_en
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [AW-1:0] PTR_MAX = AW'(MSG_LEN - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [AW:0]   LEN     = (AW+1)'(MSG_LEN);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [4:0]      msg_q [MSG_LEN];
  logic [4:0]      msg_d [MSG_LEN];
  logic [6:0]      hex_q [6];
  logic [6:0]      hex_d [6];
  logic            hex_en_q, hex_en_d;
  logic            ledr_en_q, ledr_en_d;
  logic            load_done_q, load_done_d;
  logic            pend_hex_q, pend_hex_d;
  logic            pend_ledr_q, pend_ledr_d;

  logic            step, wrap, load_ok, win_upd, ev_hex, ev_ledr;
  logic [AW:0]     win_idx  [6];
  logic [4:0]      win_code [6];
  logic [6:0]      win_seg  [6];

  // load/load_done: a write is offered by a one-cycle load strobe; if it is
  // taken, load_done pulses the next cycle, otherwise no acknowledge ever comes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    step    = 1'b0;
    wrap    = 1'b0;
    load_ok = load && !clear && (state_q != ST_RUN) && ({1'b0, load_addr} < LEN);
    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ptr_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (run) state_d = ST_RUN;
        end
        ST_RUN: begin
          // The step still happens when run drops on the terminal count.
          if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            step  = 1'b1;
            if (dir) begin
              wrap  = (ptr_q == '0);
              ptr_d = wrap ? PTR_MAX : ptr_q - AW'(1);
            end else begin
              wrap  = (ptr_q == PTR_MAX);
              ptr_d = wrap ? '0 : ptr_q + AW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
          if (!run) state_d = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (run) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    msg_d = msg_q;
    if (load_ok) msg_d[load_addr] = load_char;
  end

  // Window is taken from the post-edge pointer and message so a write or step
  // lands in the displayed pattern on the same edge.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      win_idx[k] = {1'b0, ptr_d} + (AW+1)'(5 - k);
      if (win_idx[k] >= LEN) win_idx[k] = win_idx[k] - LEN;
      win_code[k] = msg_d[win_idx[k][AW-1:0]];
    end
  end

  for (genvar g = 0; g < 6; g++) begin : g_seg
    char_to_seg u_seg (
      .code (win_code[g]),
      .seg  (win_seg[g])
    );
  end

  // A pulse that would land right after another one is held for a cycle.
  always_comb begin
    hex_d   = hex_q;
    win_upd = step || (load_ok && state_q == ST_PAUSE);
    if (clear) begin
      for (int k = 0; k < 6; k++) hex_d[k] = SEG_BLANK;
    end else if (win_upd) begin
      hex_d = win_seg;
    end
    ev_hex      = clear || win_upd || pend_hex_q;
    ev_ledr     = !clear && (wrap || pend_ledr_q);
    hex_en_d    = ev_hex && !hex_en_q;
    ledr_en_d   = ev_ledr && !hex_en_q;
    pend_hex_d  = ev_hex && hex_en_q;
    pend_ledr_d = ev_ledr && hex_en_q;
    load_done_d = load_ok;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= CH_BLANK;
      for (int k = 0; k < 6; k++) hex_q[k] <= SEG_BLANK;
      hex_en_q    <= 1'b0;
      ledr_en_q   <= 1'b0;
      load_done_q <= 1'b0;
      pend_hex_q  <= 1'b0;
      pend_ledr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      msg_q       <= msg_d;
      hex_q       <= hex_d;
      hex_en_q    <= hex_en_d;
      ledr_en_q   <= ledr_en_d;
      load_done_q <= load_done_d;
      pend_hex_q  <= pend_hex_d;
      pend_ledr_q <= pend_ledr_d;
    end
  end

  assign next_hex0 = hex_q[0];
  assign next_hex1 = hex_q[1];
  assign next_hex2 = hex_q[2];
  assign next_hex3 = hex_q[3];
  assign next_hex4 = hex_q[4];
  assign next_hex5 = hex_q[5];
  assign hex_en    = hex_en_q;
  assign ledr_en   = ledr_en_q;
  assign load_done = load_done_q;

endmodule

// File: doc/scroll_ctrl.md
SCROLL_CTRL -- requirements
Module: scroll_ctrl

Interface
REQ-001 Parameter MSG_LEN, default 16: message length in characters; legal range 6..32.
REQ-002 Parameter TICK_DIV, default 25_000_000: clk cycles per scroll step, 0.5 s at 50 MHz; legal value >=2.
REQ-003 clk  in  1  sole clock; all logic SHALL be on the rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 run  in  1  level; 1 = scroll, 0 = pause.
REQ-006 dir  in  1  0 = scroll left (ptr increments), 1 = scroll right (ptr decrements).
REQ-007 clear  in  1  one-cycle pulse; return to IDLE.
REQ-008 load  in  1  one-cycle write strobe.
REQ-009 load_addr  in  $clog2(MSG_LEN)  message slot to write.
REQ-010 load_char  in  5  character code to write.
REQ-011 load_done  out  1  one-cycle acknowledge of an accepted write.
REQ-012 next_hex0..next_hex5  out  7 each  registered active-low segment patterns for the downstream hex drivers.
REQ-013 hex_en  out  1  one-cycle pulse; next_hex* are valid and new in this cycle.
REQ-014 ledr_en  out  1  one-cycle pulse when ptr wraps.

Function
REQ-015 The block SHALL hold a MSG_LEN x 5-bit message store, a pointer ptr, and a tick counter (0..TICK_DIV-1).
REQ-016 The FSM SHALL have three states: IDLE, RUN, PAUSE.
REQ-017 FSM transitions SHALL be: IDLE->RUN on run=1; RUN->PAUSE on run=0; PAUSE->RUN on run=1; any state->IDLE on clear=1.
REQ-018 The counter SHALL increment only in RUN, hold in PAUSE, and be 0 in IDLE.
REQ-019 Step edge: in RUN with counter==TICK_DIV-1, the same edge SHALL:
- reset the counter to 0;
- set ptr to ptr+1 (dir=0) or ptr-1 (dir=1), modulo MSG_LEN;
- register the new window into next_hex*;
- assert hex_en.
REQ-020 Window mapping: next_hex5 = seg(msg[ptr]), next_hex4 = seg(msg[ptr+1]), ... next_hex0 = seg(msg[ptr+5]), all indices modulo MSG_LEN by explicit compare (non-power-of-two MSG_LEN legal).
REQ-021 ledr_en SHALL pulse with hex_en when the step wraps: MSG_LEN-1->0 (left) or 0->MSG_LEN-1 (right).
REQ-022 A load SHALL be accepted only in IDLE or PAUSE: msg[load_addr] <= load_char, with load_done=1 on the following cycle.
REQ-023 In RUN, load SHALL be ignored, with no load_done.
REQ-024 A load with load_addr >= MSG_LEN SHALL be ignored, with no load_done.
REQ-025 A load accepted in PAUSE SHALL re-register the window and pulse hex_en in the same cycle as load_done.
REQ-026 clear SHALL:
- set ptr=0 and counter=0;
- leave msg unchanged;
- set next_hex* = blank;
- pulse hex_en once on the following cycle.
REQ-027 Simultaneous clear and load: clear wins; the load SHALL be dropped with no load_done.
REQ-028 If run falls in the step cycle, the step SHALL still occur, then the FSM enters PAUSE.
REQ-029 hex_en and ledr_en SHALL never be high for two consecutive cycles; hex_en SHALL be 0 in all other cycles.
REQ-030 Character codes: 0-9 and 10-15 map to hex digits 0-F; 16 = blank (7'b1111111); 17 = dash; 18-31 = blank.

Reset
REQ-031 On reset=0 at a clk edge, reset SHALL override all inputs and set: state=IDLE, ptr=0, counter=0, every msg entry=16 (blank), next_hex*=7'b1111111, hex_en=0, ledr_en=0, load_done=0.
REQ-032 Reset asserted mid-RUN or mid-load SHALL abort the operation with no trailing pulses.

Structure
REQ-033 A shared package SHALL hold the state enum, the 5-bit character-code constants (CH_BLANK=16, CH_DASH=17), and the SEG_BLANK constant.
REQ-034 One sub-module, char_to_seg (5-bit code -> 7-bit active-low pattern, combinational), SHALL be instantiated six times.
REQ-035 The tick counter and FSM SHALL reside in scroll_ctrl.

Verification (TICK_DIV=4, MSG_LEN=8 unless stated)
REQ-036 Reset released, run=0 for 20 cycles -> all next_hex=7'h7F; hex_en, ledr_en and load_done never asserted.
REQ-037 Load codes 0..7 into slots 0..7 in IDLE, run=1, dir=0 -> each load_done follows its load by 1 cycle; hex_en every 4 cycles; first window hex5..hex0 = digits 1,2,3,4,5,6; ledr_en with the 8th hex_en (ptr 7->0).
REQ-038 dir=1 from ptr=0 -> first step gives ptr=7, window 7,0,1,2,3,4, with ledr_en=1.
REQ-039 Drop run on a step cycle -> the step still occurs, PAUSE follows; a load of code 17 at the slot shown on hex5 -> next cycle load_done=1, hex_en=1, next_hex5=dash; a load issued in RUN -> no load_done.
REQ-040 clear and load in the same cycle, with run held at 1 -> load dropped; next cycle next_hex*=7'h7F and hex_en=1; the FSM returns to RUN and the first step shows the window from ptr=1.
REQ-041 reset=0 for one cycle mid-RUN -> all outputs at reset values the next cycle; msg reads blank.
